// File: rtl/video_mem_arbiter.sv
// Single-port pixel memory arbiter: shares one memory between a scanout prefetch FIFO and a host port.
// Optional sticky underflow detection is compiled in with the macro VIDEO_ARB_UNDERFLOW_EN.
module video_mem_arbiter #(
  parameter int ADDR_W     = 19,
  parameter int DATA_W     = 24,
  parameter int FRAME_PIX  = 307200,
  parameter int FIFO_DEPTH = 4,
  parameter int LOW_WM     = 2
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              vsync,
  input  logic              pix_pop,
  output logic [DATA_W-1:0] pix_data,
  input  logic              host_req,
  input  logic              host_we,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic [DATA_W-1:0] host_wdata,
  output logic              host_gnt,
  output logic [DATA_W-1:0] host_rdata,
  output logic              host_rvalid,
  output logic              mem_en,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              underflow
);

  localparam int PTR_W = $clog2(FIFO_DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam int LVL_W = CNT_W + 1;
  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(FRAME_PIX - 1);
  localparam logic [LVL_W-1:0]  LOW_LVL   = LVL_W'(LOW_WM);
  localparam logic [LVL_W-1:0]  FULL_LVL  = LVL_W'(FIFO_DEPTH);

  typedef enum logic [1:0] {
    OWN_NONE = 2'd0,
    OWN_VID  = 2'd1,
    OWN_HOST = 2'd2
  } owner_e;

  owner_e            owner;
  logic [DATA_W-1:0] fifo_q [FIFO_DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  cnt_q, cnt_d;
  logic [ADDR_W-1:0] vid_addr_q, vid_addr_d;
  logic              inflight_q;
  logic              vsync_q;
  logic              flush_q;
  logic              rd_pend_q;
  logic [LVL_W-1:0]  lvl;
  logic              empty;
  logic              fetch;
  logic              push;
  logic              pop;

  assign empty = (cnt_q == '0);
  assign lvl   = LVL_W'(cnt_q) + LVL_W'(inflight_q);

  // Owner selection; the level counts the outstanding fetch so the FIFO can never overflow.
  always_comb begin
    owner = OWN_NONE;
    if (!reset_n) begin
      owner = OWN_NONE;
    end else if (flush_q) begin
      owner = host_req ? OWN_HOST : OWN_NONE;
    end else if (lvl < LOW_LVL) begin
      owner = OWN_VID;
    end else if (host_req) begin
      owner = OWN_HOST;
    end else if (lvl < FULL_LVL) begin
      owner = OWN_VID;
    end
  end

  assign fetch    = (owner == OWN_VID);
  assign host_gnt = (owner == OWN_HOST);

  always_comb begin
    mem_en    = 1'b0;
    mem_we    = 1'b0;
    mem_addr  = '0;
    mem_wdata = '0;
    case (owner)
      OWN_VID: begin
        mem_en   = 1'b1;
        mem_addr = vid_addr_q;
      end
      OWN_HOST: begin
        mem_en   = 1'b1;
        mem_we   = host_we;
        mem_addr = host_addr;
        if (host_we) mem_wdata = host_wdata;
      end
      default: ;
    endcase
  end

  // A return arriving in the flush cycle belongs to the old frame and is dropped.
  assign push = inflight_q & ~flush_q;
  assign pop  = pix_pop & ~empty;

  always_comb begin
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    cnt_d      = cnt_q;
    vid_addr_d = vid_addr_q;
    if (flush_q) begin
      wr_ptr_d   = '0;
      rd_ptr_d   = '0;
      cnt_d      = '0;
      vid_addr_d = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + 1'b1;
      if (pop)  rd_ptr_d = rd_ptr_q + 1'b1;
      cnt_d = cnt_q + CNT_W'(push) - CNT_W'(pop);
      if (fetch) vid_addr_d = (vid_addr_q == LAST_ADDR) ? '0 : vid_addr_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      cnt_q      <= '0;
      vid_addr_q <= '0;
      inflight_q <= 1'b0;
      vsync_q    <= 1'b0;
      flush_q    <= 1'b0;
      rd_pend_q  <= 1'b0;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      cnt_q      <= cnt_d;
      vid_addr_q <= vid_addr_d;
      inflight_q <= fetch;
      vsync_q    <= vsync;
      flush_q    <= vsync & ~vsync_q;
      rd_pend_q  <= host_gnt & ~host_we;
    end
  end

  always_ff @(posedge clk) begin
    if (push) fifo_q[wr_ptr_q] <= mem_rdata;
  end

  assign pix_data    = empty ? '0 : fifo_q[rd_ptr_q];
  assign host_rvalid = rd_pend_q;
  assign host_rdata  = rd_pend_q ? mem_rdata : '0;

`ifdef VIDEO_ARB_UNDERFLOW_EN
  logic udf_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      udf_q <= 1'b0;
    end else if (flush_q) begin
      udf_q <= 1'b0;
    end else if (pix_pop && empty) begin
      udf_q <= 1'b1;
    end
  end

  assign underflow = udf_q;
`else
  assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_video_mem_arbiter.sv
// Bench for video_mem_arbiter: directed steps plus randomized traffic against a queue-based reference model.
// Honors VIDEO_ARB_UNDERFLOW_EN the same way the design does.
module tb_video_mem_arbiter;

  localparam int ADDR_W     = 19;
  localparam int DATA_W     = 24;
  localparam int FRAME_PIX  = 40;
  localparam int FIFO_DEPTH = 4;
  localparam int LOW_WM     = 2;
`ifdef VIDEO_ARB_UNDERFLOW_EN
  localparam bit UDF_EN = 1'b1;
`else
  localparam bit UDF_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              reset_n = 1'b0;
  logic              vsync = 1'b0;
  logic              pix_pop = 1'b0;
  logic [DATA_W-1:0] pix_data;
  logic              host_req = 1'b0;
  logic              host_we = 1'b0;
  logic [ADDR_W-1:0] host_addr = '0;
  logic [DATA_W-1:0] host_wdata = '0;
  logic              host_gnt;
  logic [DATA_W-1:0] host_rdata;
  logic              host_rvalid;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata = '0;
  logic              underflow;

  video_mem_arbiter #(
    .ADDR_W(ADDR_W), .DATA_W(DATA_W), .FRAME_PIX(FRAME_PIX),
    .FIFO_DEPTH(FIFO_DEPTH), .LOW_WM(LOW_WM)
  ) dut (
    .clk(clk), .reset_n(reset_n), .vsync(vsync), .pix_pop(pix_pop), .pix_data(pix_data),
    .host_req(host_req), .host_we(host_we), .host_addr(host_addr), .host_wdata(host_wdata),
    .host_gnt(host_gnt), .host_rdata(host_rdata), .host_rvalid(host_rvalid),
    .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .underflow(underflow)
  );

  always #5 clk = ~clk;

  function automatic logic [DATA_W-1:0] init_pix(int a);
    return DATA_W'(a * 32'h9E37 + 32'h51);
  endfunction

  // Synchronous single-port memory with one cycle of read latency.
  logic [DATA_W-1:0] ram [int];
  always @(posedge clk) begin
    if (mem_en && mem_we) begin
      ram[int'(mem_addr)] = mem_wdata;
      mem_rdata <= DATA_W'($urandom);
    end else if (mem_en) begin
      mem_rdata <= ram.exists(int'(mem_addr)) ? ram[int'(mem_addr)] : init_pix(int'(mem_addr));
    end else begin
      mem_rdata <= DATA_W'($urandom);
    end
  end

  // Reference model state
  logic [DATA_W-1:0] img [int];
  logic [DATA_W-1:0] q_pix [$];
  bit                vid_pend;
  logic [DATA_W-1:0] vid_val;
  int                vid_addr;
  bit                rd_pend;
  logic [DATA_W-1:0] rd_val;
  bit                flush_pend;
  bit                vs_prev;
  bit                udf;
  int                exp_owner;   // 0 none, 1 video, 2 host
  bit                h_active;

  int n_vec = 0;
  int n_err = 0;

  function automatic logic [DATA_W-1:0] img_rd(int a);
    if (img.exists(a)) return img[a];
    return init_pix(a);
  endfunction

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_vec++;
    assert (got === exp) else begin
      n_err++;
      $error("FAIL %s: observed %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic model_reset();
    q_pix.delete();
    vid_pend   = 1'b0;
    vid_addr   = 0;
    rd_pend    = 1'b0;
    flush_pend = 1'b0;
    vs_prev    = 1'b0;
    udf        = 1'b0;
  endtask

  task automatic predict();
    int level;
    level = q_pix.size() + (vid_pend ? 1 : 0);
    if (flush_pend)             exp_owner = host_req ? 2 : 0;
    else if (level < LOW_WM)    exp_owner = 1;
    else if (host_req)          exp_owner = 2;
    else if (level < FIFO_DEPTH) exp_owner = 1;
    else                        exp_owner = 0;
  endtask

  task automatic check_outputs();
    predict();
    chk("host_gnt", 64'(host_gnt), 64'(exp_owner == 2));
    chk("mem_en", 64'(mem_en), 64'(exp_owner != 0));
    chk("mem_we", 64'(mem_we), 64'(exp_owner == 2 && host_we));
    if (exp_owner == 1) chk("mem_addr_vid", 64'(mem_addr), 64'(vid_addr));
    if (exp_owner == 2) chk("mem_addr_host", 64'(mem_addr), 64'(host_addr));
    if (exp_owner == 2 && host_we) chk("mem_wdata", 64'(mem_wdata), 64'(host_wdata));
    chk("pix_data", 64'(pix_data), (q_pix.size() > 0) ? 64'(q_pix[0]) : 64'(0));
    chk("host_rvalid", 64'(host_rvalid), 64'(rd_pend));
    chk("host_rdata", 64'(host_rdata), rd_pend ? 64'(rd_val) : 64'(0));
    chk("underflow", 64'(underflow), 64'(udf));
  endtask

  task automatic model_advance();
    bit empty_pop;
    bit push;
    logic [DATA_W-1:0] pv;
    empty_pop = pix_pop && (q_pix.size() == 0);
    push      = vid_pend && !flush_pend;
    pv        = vid_val;
    if (pix_pop && !empty_pop) void'(q_pix.pop_front());
    if (push) q_pix.push_back(pv);
    if (exp_owner == 2) begin
      rd_pend = !host_we;
      rd_val  = img_rd(int'(host_addr));
      if (host_we) img[int'(host_addr)] = host_wdata;
    end else begin
      rd_pend = 1'b0;
    end
    if (exp_owner == 1) begin
      vid_val  = img_rd(vid_addr);
      vid_pend = 1'b1;
      vid_addr = (vid_addr + 1) % FRAME_PIX;
    end else begin
      vid_pend = 1'b0;
    end
    if (flush_pend) begin
      q_pix.delete();
      vid_addr = 0;
      udf      = 1'b0;
    end else if (empty_pop && UDF_EN) begin
      udf = 1'b1;
    end
    flush_pend = vsync && !vs_prev;
    vs_prev    = vsync;
  endtask

  task automatic run_cycle();
    #2;
    check_outputs();
    model_advance();
    @(negedge clk);
  endtask

  task automatic drive(input bit pop, input int host_pct, input bit vs);
    if (!h_active && ($urandom_range(99) < host_pct)) begin
      h_active   = 1'b1;
      host_we    = 1'($urandom_range(1));
      host_addr  = ADDR_W'($urandom_range(FRAME_PIX - 1));
      host_wdata = DATA_W'($urandom);
    end
    host_req = h_active;
    if (!h_active) begin
      host_we    = 1'b0;
      host_addr  = '0;
      host_wdata = '0;
    end
    pix_pop = pop;
    vsync   = vs;
    run_cycle();
    if (exp_owner == 2) h_active = 1'b0;
  endtask

  task automatic reset_check();
    chk("rst_host_gnt", 64'(host_gnt), 64'(0));
    chk("rst_host_rvalid", 64'(host_rvalid), 64'(0));
    chk("rst_host_rdata", 64'(host_rdata), 64'(0));
    chk("rst_mem_en", 64'(mem_en), 64'(0));
    chk("rst_mem_we", 64'(mem_we), 64'(0));
    chk("rst_mem_addr", 64'(mem_addr), 64'(0));
    chk("rst_mem_wdata", 64'(mem_wdata), 64'(0));
    chk("rst_pix_data", 64'(pix_data), 64'(0));
    chk("rst_underflow", 64'(underflow), 64'(0));
  endtask

  task automatic drain_host();
    for (int i = 0; i < 20 && h_active; i++) drive(1'b0, 0, 1'b0);
    chk("host_drained", 64'(h_active), 64'(0));
  endtask

  initial begin
    h_active = 1'b0;
    model_reset();
    // Reset with a write request and a pop held active: everything must stay quiet.
    host_req = 1'b1; host_we = 1'b1; host_addr = ADDR_W'(7); host_wdata = DATA_W'(24'hABCDEF);
    pix_pop = 1'b1;
    repeat (3) @(negedge clk);
    #2 reset_check();
    host_req = 1'b0; host_we = 1'b0; host_addr = '0; host_wdata = '0; pix_pop = 1'b0;
    @(negedge clk);
    reset_n = 1'b1;

    // Idle fill: fetches 0..3, then the memory goes idle with the FIFO full.
    repeat (6) drive(1'b0, 0, 1'b0);

    // Host read of 0x100 against a full FIFO, response one cycle later.
    h_active = 1'b1; host_we = 1'b0; host_addr = ADDR_W'(12'h100); host_wdata = '0;
    drive(1'b0, 0, 1'b0);
    chk("host_0x100_granted", 64'(h_active), 64'(0));
    drive(1'b0, 0, 1'b0);

    // Continuous scanout with the host always asking: video wins below the watermark.
    repeat (30) drive(1'b1, 100, 1'b0);
    drain_host();
    repeat (4) drive(1'b0, 0, 1'b0);

    // vsync while a fetch is in flight with three pixels queued.
    drive(1'b1, 0, 1'b0);
    drive(1'b0, 0, 1'b1);
    drive(1'b0, 0, 1'b1);
    // Pop from the empty FIFO right after the flush, then clear underflow with another vsync.
    drive(1'b1, 0, 1'b0);
    repeat (3) drive(1'b0, 0, 1'b0);
    drive(1'b0, 0, 1'b1);
    repeat (4) drive(1'b0, 0, 1'b0);

    // Randomized traffic.
    for (int i = 0; i < 3000; i++)
      drive(1'($urandom_range(99) < 60), 30, 1'($urandom_range(149) == 0));
    drain_host();

    // Long continuous scanout across several frame wraps.
    drive(1'b0, 0, 1'b1);
    repeat (3) drive(1'b0, 0, 1'b0);
    repeat (4 * FRAME_PIX) drive(1'b1, 0, 1'b0);

    // Reset asserted right after a host read grant drops the response.
    repeat (6) drive(1'b0, 0, 1'b0);
    h_active = 1'b1; host_we = 1'b0; host_addr = ADDR_W'(3); host_wdata = '0;
    host_req = 1'b1; pix_pop = 1'b0; vsync = 1'b0;
    #2 check_outputs();
    chk("mid_rst_grant", 64'(host_gnt), 64'(1));
    model_advance();
    @(posedge clk);
    #1 reset_n = 1'b0;
    #1 reset_check();
    host_req = 1'b0; h_active = 1'b0;
    model_reset();
    @(negedge clk);
    @(negedge clk);
    reset_n = 1'b1;
    repeat (10) drive(1'b0, 0, 1'b0);
    repeat (40) drive(1'($urandom_range(1)), 20, 1'b0);
    drain_host();

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/video_mem_arbiter.md
VIDEO_MEM_ARBITER -- requirements
Module: video_mem_arbiter

Interface
REQ-001 Parameter ADDR_W, 19, pixel memory address width.
REQ-002 Parameter DATA_W, 24, pixel word width ({red,green,blue}).
REQ-003 Parameter FRAME_PIX, 307200, pixels per frame (640x480).
REQ-004 Parameter FIFO_DEPTH, 4, scanout prefetch FIFO entries, power of two.
REQ-005 Parameter LOW_WM, 2, FIFO occupancy (incl. in-flight) below which scanout has priority.
REQ-006 Ports: clk in 1 pixel clock; reset_n in 1 reset. Clock is clk and reset is reset_n, with a single clock domain; reset is asynchronous and active-low.
REQ-007 Ports: vsync in 1 frame restart; pix_pop in 1 consume one scanout pixel (active video).
REQ-008 Ports: pix_data out DATA_W scanout pixel, valid on the cycle pix_pop is high.
REQ-009 Ports: host_req in 1; host_we in 1; host_addr in ADDR_W; host_wdata in DATA_W; host_gnt out 1 accepted this cycle.
REQ-010 Ports: host_rdata out DATA_W; host_rvalid out 1, one-cycle pulse.
REQ-011 Ports: mem_en out 1; mem_we out 1; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, with fixed 1-cycle read latency.
REQ-012 Ports: underflow out 1, sticky scanout-underflow flag.

Function
REQ-013 Single-port memory: at most one access (mem_en) per cycle; owner is VID, HOST or NONE.
REQ-014 Owner selection: VID if occupancy+inflight < LOW_WM; else HOST if host_req; else VID if occupancy+inflight < FIFO_DEPTH; else NONE.
REQ-015 host_gnt is combinational, high in the cycle HOST owns memory; the host holds req/we/addr/wdata stable until granted.
REQ-016 Host write: mem_we=1 in the grant cycle; no response pulse.
REQ-017 Host read: host_rvalid=1 and host_rdata=mem_rdata exactly 1 cycle after the grant.
REQ-018 VID fetch: mem_addr=vid_addr, and vid_addr increments by one per fetch; at FRAME_PIX-1 it wraps to 0.
REQ-019 The VID read returns next cycle and is pushed to the FIFO; in-flight count is 0 or 1.
REQ-020 FIFO is first-word fall-through: pix_data = head entry, and pix_pop removes the head.
REQ-021 Simultaneous push and pop: occupancy unchanged, order preserved.
REQ-022 pix_pop when empty: pix_data=0, no state change, underflow set (if compiled in).
REQ-023 vsync rising edge (registered detect): next cycle flush FIFO, vid_addr:=0, and discard any in-flight VID return (no push). A host transaction in flight completes normally.
REQ-024 A flush cycle issues no VID fetch; HOST may be granted in that cycle.
REQ-025 Fetches are never issued that could overflow the FIFO: occupancy+inflight <= FIFO_DEPTH at all times.

Reset
REQ-026 On reset_n low the FIFO is empty and vid_addr=0, inflight=0 and the vsync detect register=0.
REQ-027 On reset_n low all outputs are 0: host_gnt, host_rvalid, host_rdata, mem_en, mem_we, mem_addr, mem_wdata, pix_data and underflow.
REQ-028 After reset deassertion the first cycle may fetch VID (FIFO empty gives priority).
REQ-029 Reset asserted mid-transaction drops any pending read response; no host_rvalid is produced.

Configuration
REQ-030 Macro VIDEO_ARB_UNDERFLOW_EN: when defined, underflow is set on a pop-when-empty and cleared only by reset or vsync flush.
REQ-031 Without VIDEO_ARB_UNDERFLOW_EN, underflow is tied to 0 and no detection logic is built; all other behaviour is identical.

Verification
REQ-032 Reset, no host, pix_pop low -> fetch addr 0,1,2,3 on consecutive cycles, then mem_en low with FIFO full (4).
REQ-033 FIFO full, host read addr 0x100 -> host_gnt same cycle, host_rvalid+data next cycle; during a continuous pix_pop with occupancy <2, VID wins over a pending host_req.
REQ-034 Pop pixel 0..FRAME_PIX-1 continuously -> mem_addr wraps 307199 to 0; pix_data matches the memory model in order.
REQ-035 vsync pulse while a VID read is in flight and FIFO holds 3 -> FIFO empty after flush, stale data not pushed, next fetch addr 0.
REQ-036 pix_pop with FIFO empty -> pix_data=0 and underflow=1 (with macro) or 0 (without); underflow clears on the next vsync.
